poly_acc: RTL

//   Downstream consumer of the polynomial evaluator's y stream. On start, it collects n_samp

---
 rtl/poly_pkg.sv | 17 +
 rtl/poly_acc_if.sv | 28 ++
 rtl/signed_minmax.sv | 35 +++
 rtl/poly_acc.sv | 96 +++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared types and helpers for the polynomial accumulator
package poly_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACCUM,
    ACC_DONE
  } acc_state_t;

  // Two's-complement add overflow: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/poly_acc_if.sv
// rtl/poly_acc_if.sv - sample input, control and result handshake bundle
interface poly_acc_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int NW        = 8
);
  logic                        start;
  logic [NW-1:0]               n_samp;
  logic                        in_valid;
  logic signed [WIDTH-1:0]     in_data;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic signed [WIDTH-1:0]     out_min;
  logic signed [WIDTH-1:0]     out_max;
  logic                        out_ovf;

  modport master (
    output start, n_samp, in_valid, in_data, out_ready,
    input  busy, out_valid, out_sum, out_min, out_max, out_ovf
  );

  modport slave (
    input  start, n_samp, in_valid, in_data, out_ready,
    output busy, out_valid, out_sum, out_min, out_max, out_ovf
  );
endinterface

// File: rtl/signed_minmax.sv
// rtl/signed_minmax.sv - registered running signed min/max with clear and zero load
module signed_minmax #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    zero,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] min_val,
  output logic signed [WIDTH-1:0] max_val
);

  localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Zero load wins over clear; clear seeds extremes so the first sample always replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= '0;
      max_val <= '0;
    end else if (zero) begin
      min_val <= '0;
      max_val <= '0;
    end else if (clear) begin
      min_val <= POS_MAX;
      max_val <= NEG_MIN;
    end else if (en) begin
      if (din < min_val) min_val <= din;
      if (din > max_val) max_val <= din;
    end
  end

endmodule

// File: rtl/poly_acc.sv
// rtl/poly_acc.sv - windowed signed sum/min/max of a sample stream with result handshake
module poly_acc
  import poly_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = 32,
  parameter int NW        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  poly_acc_if.slave   bus
);

  acc_state_t                  state_q, state_d;
  logic [NW-1:0]               n_q;
  logic [NW-1:0]               count_q;
  logic [NW-1:0]               count_inc;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] sum_next;
  logic                        ovf_q;
  logic                        accept_start;
  logic                        take;
  logic                        last;
  logic                        mm_clear;
  logic                        mm_zero;

  assign accept_start = (state_q == ACC_IDLE) && bus.start;
  assign take         = (state_q == ACC_ACCUM) && bus.in_valid;
  assign count_inc    = count_q + 1'b1;
  assign last         = take && (count_inc == n_q);
  assign in_ext       = ACC_WIDTH'(bus.in_data);
  assign sum_next     = sum_q + in_ext;
  assign mm_zero      = accept_start && (bus.n_samp == '0);
  assign mm_clear     = accept_start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an empty window goes straight to DONE with zeroed results.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_IDLE: begin
        if (bus.start) state_d = (bus.n_samp == '0) ? ACC_DONE : ACC_ACCUM;
      end
      ACC_ACCUM: begin
        if (last) state_d = ACC_DONE;
      end
      ACC_DONE: begin
        if (bus.out_ready) state_d = ACC_IDLE;
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  // Window length, sample counter, accumulator and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept_start) begin
      n_q     <= bus.n_samp;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (take) begin
      count_q <= count_inc;
      sum_q   <= sum_next;
      if (add_ovf(sum_q[ACC_WIDTH-1], in_ext[ACC_WIDTH-1], sum_next[ACC_WIDTH-1]))
        ovf_q <= 1'b1;
    end
  end

  signed_minmax #(.WIDTH(WIDTH)) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mm_clear),
    .zero    (mm_zero),
    .en      (take),
    .din     (bus.in_data),
    .min_val (bus.out_min),
    .max_val (bus.out_max)
  );

  assign bus.busy      = (state_q != ACC_IDLE);
  assign bus.out_valid = (state_q == ACC_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

endmodule
